conv_channel_accum: RTL and testbench
=====================================

CONV_CHANNEL_ACCUM -- requirements
Module: conv_channel_accum

Interface
REQ-001 SHALL have parameter dwidth, default 16: signed lane width of din, bias and dout.
REQ-002 SHALL have parameter qwidth, default 11: fractional bits, shared by din, bias and dout, so no shifting is needed.
REQ-003 SHALL have parameter PE_Num, default 8: lane count.
REQ-004 SHALL have parameter awidth, default 24: signed accumulator width per lane (awidth > dwidth).
REQ-005 SHALL have parameter depth, default 64: partial-sum buffer entries (pixels per pass).
REQ-006 SHALL have parameter max_cin, default 16: maximum number of input channels.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port start, input, 1 bit: job start pulse; latches configuration.
REQ-010 SHALL have port cin_num, input, clog2(max_cin)+1 bits: input channels per job.
REQ-011 SHALL have port pix_num, input, clog2(depth)+1 bits: pixels per channel pass.
REQ-012 SHALL have port bias_en, input, 1 bit: add bias on the final pass.
REQ-013 SHALL have port relu_en, input, 1 bit: clamp negative outputs to 0.
REQ-014 SHALL have port din_valid, input, 1 bit: din beat valid.
REQ-015 SHALL have port din_ready, output, 1 bit: beat accepted when din_valid && din_ready.
REQ-016 SHALL have port din, input, PE_Num*dwidth bits: signed lane i at [i*dwidth +: dwidth].
REQ-017 SHALL have port bias, input, PE_Num*dwidth bits: signed per-lane bias, sampled at start.
REQ-018 SHALL have port dout_valid, output, 1 bit: output beat valid.
REQ-019 SHALL have port dout_ready, input, 1 bit: downstream accept.
REQ-020 SHALL have port dout, output, PE_Num*dwidth bits: final saturated per-lane result.
REQ-021 SHALL have port busy, output, 1 bit: high in states RUN and DRAIN.
REQ-022 SHALL have port done, output, 1 bit: one-cycle pulse at job end.
REQ-023 SHALL have port sat_flag, output, 1 bit: sticky flag, set if any lane saturated this job.

Function
REQ-024 SHALL implement FSM states IDLE, RUN and DRAIN with these transitions:
- IDLE->RUN on start.
- RUN->DRAIN on acceptance of the beat where pix_cnt=pix_num-1 and cin_cnt=cin_num-1.
- DRAIN->IDLE when dout_valid is 0, or when dout_valid && dout_ready.
REQ-025 SHALL, on start in IDLE, latch cin_num, pix_num, bias_en, relu_en and bias; clamp cin_num to 1..max_cin and pix_num to 1..depth; clear pix_cnt, cin_cnt and sat_flag.
REQ-026 SHALL ignore start while not in IDLE.
REQ-027 SHALL drive din_ready=1 only in RUN, except on a final pass (cin_cnt=cin_num-1) with dout_valid=1 and dout_ready=0.
REQ-028 SHALL drop din_valid outside RUN with no state change.
REQ-029 SHALL, per accepted beat, advance pix_cnt and wrap it at pix_num-1 to 0, incrementing cin_cnt on each wrap.
REQ-030 SHALL, on the first pass (cin_cnt=0), write each lane's sign-extended din into psum[pix_cnt].
REQ-031 SHALL, on a later pass, write psum[pix_cnt]+din into psum[pix_cnt], saturating to the awidth signed range.
REQ-032 SHALL perform the psum update as a single-cycle read-modify-write, with the write taking effect at the accepting edge; with pix_num=1, back-to-back beats accumulate correctly.
REQ-033 SHALL, on a final-pass beat, compute per lane s = psum_next + (bias_en ? bias : 0), where psum_next is the REQ-030/031 result.
REQ-034 SHALL saturate s to the dwidth signed range, then apply relu_en (negative -> 0), and register the result into dout with dout_valid=1 on the next edge.
REQ-035 SHALL set sat_flag if dwidth saturation or awidth saturation occurs in any lane.
REQ-036 SHALL hold dout and dout_valid stable while dout_valid && !dout_ready.
REQ-037 SHALL clear dout_valid after acceptance unless a new final-pass beat is accepted in the same cycle; in that case the new result replaces the old one without a gap.
REQ-038 SHALL give a latency of 1 cycle from final-pass din acceptance to dout_valid, with a throughput of 1 beat per cycle.
REQ-039 SHALL pulse done for 1 cycle on the DRAIN->IDLE transition.
REQ-040 SHALL allow a start in the same cycle as done to be ignored; the next start is honoured in IDLE.
REQ-041 SHALL, when cin_num=1, treat every beat as both first and final pass: dout = sat(din + bias).
REQ-042 SHALL leave psum contents undefined between jobs; psum is always overwritten on pass 0.

Reset
REQ-043 SHALL, on rst_n=0 at a clock edge, set state=IDLE, din_ready=0, dout_valid=0, dout=0, busy=0, done=0, sat_flag=0, and pix_cnt=cin_cnt=0.
REQ-044 SHALL allow reset mid-job to abort the job, drop any pending output and produce no done pulse; the psum buffer needs no reset.

Verification
REQ-045 SHALL cover: PE_Num=8, cin_num=3, pix_num=4, all din lanes=0x0100 (0.125), bias=0x0080, bias_en=1 -> four dout beats of 0x0380 per lane, then done, and sat_flag=0.
REQ-046 SHALL cover: cin_num=2, pix_num=1, din=0x7000 then 0x7000 back-to-back -> dout=0x7FFF, sat_flag=1.
REQ-047 SHALL cover: relu_en=1, cin_num=1, din=0xFF00, bias=0 -> dout=0x0000; with relu_en=0 -> 0xFF00.
REQ-048 SHALL cover: final pass with dout_ready held 0 for 3 cycles -> din_ready=0 and dout stable for 3 cycles, with no beat lost after release.
REQ-049 SHALL cover: rst_n=0 during cin_cnt=1, then a new start with cin_num=1 -> outputs match the fresh job, and no done from the aborted job.
REQ-050 SHALL cover: cin_num=0 and pix_num=0 at start -> behaves as 1/1, giving a single output beat and then done.

Source files
------------

// File: rtl/conv_channel_accum_if.sv
// Stream bundle for conv_channel_accum: din beat input plus dout result output.
//   master: drives din_valid/din and dout_ready (producer of pixels, consumer of results)
//   slave : drives din_ready, dout_valid and dout (the accumulator)
interface conv_channel_accum_if #(
    parameter int unsigned dwidth = 16,
    parameter int unsigned PE_Num = 8
);
    logic                     din_valid;
    logic                     din_ready;
    logic [PE_Num*dwidth-1:0] din;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [PE_Num*dwidth-1:0] dout;

    modport master (
        output din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout
    );

    modport slave (
        input  din_valid, din, dout_ready,
        output din_ready, dout_valid, dout
    );
endinterface

// File: rtl/conv_channel_accum.sv
// Multi-channel partial-sum accumulator for a PE_Num-lane convolution engine.
// Each job runs cin_num passes over pix_num pixels; pass 0 loads psum, later passes add,
// and the final pass adds an optional bias, saturates to dwidth, applies optional ReLU
// and emits one dout beat per pixel.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : job start pulse (IDLE only); latches cin_num, pix_num, bias_en,
//                       relu_en and bias
//   bus (slave)       : din_valid/din_ready/din input beats, dout_valid/dout_ready/dout results
//   busy              : job in progress (RUN or DRAIN)
//   done              : one-cycle pulse when the job finishes
//   sat_flag          : sticky per-job saturation indicator
module conv_channel_accum #(
    parameter int unsigned dwidth  = 16,
    parameter int unsigned qwidth  = 11,
    parameter int unsigned PE_Num  = 8,
    parameter int unsigned awidth  = 24,
    parameter int unsigned depth   = 64,
    parameter int unsigned max_cin = 16,
    localparam int unsigned CW     = $clog2(max_cin) + 1,
    localparam int unsigned PW     = $clog2(depth) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CW-1:0]            cin_num,
    input  logic [PW-1:0]            pix_num,
    input  logic                     bias_en,
    input  logic                     relu_en,
    input  logic [PE_Num*dwidth-1:0] bias,
    conv_channel_accum_if.slave      bus,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);
    // din, bias and dout share the same Q format, so no alignment shift is needed.
    if (qwidth >= dwidth || awidth <= dwidth) begin : g_param_check
        $error("conv_channel_accum: requires qwidth < dwidth < awidth");
    end

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam int unsigned IW  = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned DLW = PE_Num * dwidth;
    localparam int unsigned PLW = PE_Num * awidth;

    localparam logic signed [awidth:0] DMax = {{(awidth-dwidth+2){1'b0}}, {(dwidth-1){1'b1}}};
    localparam logic signed [awidth:0] DMin = {{(awidth-dwidth+2){1'b1}}, {(dwidth-1){1'b0}}};

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cin_num_q, cin_num_d, cin_cnt_q, cin_cnt_d;
    logic [PW-1:0]  pix_num_q, pix_num_d, pix_cnt_q, pix_cnt_d;
    logic           bias_en_q, bias_en_d, relu_en_q, relu_en_d;
    logic [DLW-1:0] bias_q, bias_d, dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d, sat_q, sat_d;

    logic [PLW-1:0] psum_q [depth];
    logic [PLW-1:0] psum_next;
    logic [DLW-1:0] result;
    logic           any_sat;

    logic first_pass, final_pass, last_pix, din_ready, accept;
    logic [IW-1:0] idx;

    logic signed [dwidth-1:0] lane_din, lane_bias, lane_out;
    logic signed [awidth-1:0] lane_psum, lane_next;
    logic signed [awidth:0]   rmw_sum, fin_sum;
    logic                     lane_asat, lane_dsat;

    assign idx        = pix_cnt_q[IW-1:0];
    assign first_pass = (cin_cnt_q == '0);
    assign final_pass = (cin_cnt_q == cin_num_q - 1'b1);
    assign last_pix   = (pix_cnt_q == pix_num_q - 1'b1);

    // Stall input only when a final-pass result would overwrite an unaccepted one.
    assign din_ready  = (state_q == StRun) && !(final_pass && dout_valid_q && !bus.dout_ready);
    assign accept     = bus.din_valid && din_ready;

    // Per-lane read-modify-write of the partial sum plus final-pass bias/saturate/ReLU.
    always_comb begin
        psum_next = '0;
        result    = '0;
        any_sat   = 1'b0;
        lane_din  = '0;
        lane_bias = '0;
        lane_out  = '0;
        lane_psum = '0;
        lane_next = '0;
        rmw_sum   = '0;
        fin_sum   = '0;
        lane_asat = 1'b0;
        lane_dsat = 1'b0;
        for (int i = 0; i < int'(PE_Num); i++) begin
            lane_din  = bus.din[i*dwidth +: dwidth];
            lane_bias = bias_en_q ? bias_q[i*dwidth +: dwidth] : '0;
            lane_psum = psum_q[idx][i*awidth +: awidth];
            lane_asat = 1'b0;
            lane_dsat = 1'b0;
            rmw_sum   = {lane_psum[awidth-1], lane_psum}
                      + {{(awidth-dwidth+1){lane_din[dwidth-1]}}, lane_din};
            if (first_pass) begin
                lane_next = {{(awidth-dwidth){lane_din[dwidth-1]}}, lane_din};
            end else if (rmw_sum[awidth] != rmw_sum[awidth-1]) begin
                lane_asat = 1'b1;
                lane_next = rmw_sum[awidth] ? {1'b1, {(awidth-1){1'b0}}}
                                            : {1'b0, {(awidth-1){1'b1}}};
            end else begin
                lane_next = rmw_sum[awidth-1:0];
            end

            fin_sum = {lane_next[awidth-1], lane_next}
                    + {{(awidth-dwidth+1){lane_bias[dwidth-1]}}, lane_bias};
            if (fin_sum > DMax) begin
                lane_dsat = 1'b1;
                lane_out  = {1'b0, {(dwidth-1){1'b1}}};
            end else if (fin_sum < DMin) begin
                lane_dsat = 1'b1;
                lane_out  = {1'b1, {(dwidth-1){1'b0}}};
            end else begin
                lane_out = fin_sum[dwidth-1:0];
            end
            if (relu_en_q && lane_out[dwidth-1]) begin
                lane_out = '0;
            end

            psum_next[i*awidth +: awidth] = lane_next;
            result[i*dwidth +: dwidth]    = lane_out;
            any_sat = any_sat | lane_asat | (final_pass & lane_dsat);
        end
    end

    always_comb begin
        state_d      = state_q;
        cin_num_d    = cin_num_q;
        pix_num_d    = pix_num_q;
        bias_en_d    = bias_en_q;
        relu_en_d    = relu_en_q;
        bias_d       = bias_q;
        cin_cnt_d    = cin_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        sat_d        = sat_q;
        done         = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !bus.dout_ready;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (cin_num == '0) begin
                        cin_num_d = CW'(1);
                    end else if (cin_num > CW'(max_cin)) begin
                        cin_num_d = CW'(max_cin);
                    end else begin
                        cin_num_d = cin_num;
                    end
                    if (pix_num == '0) begin
                        pix_num_d = PW'(1);
                    end else if (pix_num > PW'(depth)) begin
                        pix_num_d = PW'(depth);
                    end else begin
                        pix_num_d = pix_num;
                    end
                    bias_en_d = bias_en;
                    relu_en_d = relu_en;
                    bias_d    = bias;
                    cin_cnt_d = '0;
                    pix_cnt_d = '0;
                    sat_d     = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    if (any_sat) begin
                        sat_d = 1'b1;
                    end
                    if (final_pass) begin
                        dout_valid_d = 1'b1;
                        dout_d       = result;
                    end
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        if (final_pass) begin
                            cin_cnt_d = '0;
                            state_d   = StDrain;
                        end else begin
                            cin_cnt_d = cin_cnt_q + 1'b1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!dout_valid_q || bus.dout_ready) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cin_num_q    <= '0;
            pix_num_q    <= '0;
            bias_en_q    <= 1'b0;
            relu_en_q    <= 1'b0;
            bias_q       <= '0;
            cin_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            sat_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cin_num_q    <= cin_num_d;
            pix_num_q    <= pix_num_d;
            bias_en_q    <= bias_en_d;
            relu_en_q    <= relu_en_d;
            bias_q       <= bias_d;
            cin_cnt_q    <= cin_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            sat_q        <= sat_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Partial-sum buffer: no reset, every job overwrites it on pass 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            psum_q[idx] <= psum_next;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign busy           = (state_q != StIdle);
    assign sat_flag       = sat_q;
endmodule

// File: tb/tb_conv_channel_accum.sv
module tb_conv_channel_accum;
    localparam int DW    = 16;
    localparam int PE    = 8;
    localparam int AW    = 24;
    localparam int DEPTH = 64;
    localparam int MAXC  = 16;
    localparam int CW    = $clog2(MAXC) + 1;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int W     = PE * DW;

    typedef struct {
        logic [CW-1:0]        cin;
        logic [PW-1:0]        pix;
        int                   ncin;
        int                   npix;
        bit                   ben;
        bit                   ren;
        logic [2:0][DW-1:0]   d;
        logic [DW-1:0]        b;
        logic [DW-1:0]        ex;
        bit                   sat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cin_num = '0;
    logic [PW-1:0] pix_num = '0;
    logic          bias_en = 1'b0;
    logic          relu_en = 1'b0;
    logic [W-1:0]  bias = '0;
    logic          busy, done, sat_flag;

    int total = 0;
    int bad = 0;
    int out_cnt = 0;
    int done_cnt = 0;
    logic [W-1:0] sb_q [$];

    conv_channel_accum_if #(.dwidth(DW), .PE_Num(PE)) bus ();

    conv_channel_accum #(
        .dwidth(DW), .qwidth(11), .PE_Num(PE), .awidth(AW), .depth(DEPTH), .max_cin(MAXC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cin_num(cin_num),
        .pix_num(pix_num),
        .bias_en(bias_en),
        .relu_en(relu_en),
        .bias(bias),
        .bus(bus.slave),
        .busy(busy),
        .done(done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [DW-1:0] v);
        return {PE{v}};
    endfunction

    // Drive one beat and wait for acceptance; a final-pass beat queues its expected result.
    task automatic send(input logic [W-1:0] d, input bit fin, input logic [W-1:0] req);
        bit acc = 1'b0;
        bus.din_valid = 1'b1;
        bus.din = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (bus.din_ready) begin
                acc = 1'b1;
                if (fin) sb_q.push_back(req);
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no din_ready expected acceptance within 50 cycles");
        end
    endtask

    task automatic do_start(input logic [CW-1:0] c, input logic [PW-1:0] p, input bit be,
                            input bit re, input logic [W-1:0] b);
        cin_num = c; pix_num = p; bias_en = be; relu_en = re; bias = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config after start to prove it was latched.
        cin_num = CW'(7); pix_num = PW'(9); bias = ~b; bias_en = ~be; relu_en = ~re;
        @(negedge clk);
        check("busy_after_start", {{(W-1){1'b0}}, busy}, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            @(posedge clk); #1;
        end
        check(name, {{(W-1){1'b0}}, got}, 1);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int oc0 = out_cnt;
        do_start(v.cin, v.pix, v.ben, v.ren, rep(v.b));
        for (int c = 0; c < v.ncin; c++) begin
            for (int p = 0; p < v.npix; p++) begin
                send(rep(v.d[(c > 2) ? 2 : c]), c == v.ncin - 1, rep(v.ex));
            end
        end
        bus.din_valid = 1'b0;
        wait_done($sformatf("vec%0d_done", n));
        check($sformatf("vec%0d_outs", n), W'(out_cnt - oc0), W'(v.npix));
        check($sformatf("vec%0d_sat", n), {{(W-1){1'b0}}, sat_flag}, {{(W-1){1'b0}}, v.sat});
        check($sformatf("vec%0d_idle", n), {{(W-1){1'b0}}, busy}, 0);
    endtask

    initial begin
        vec_t vecs [9];
        logic [W-1:0] rd [3][5];
        logic [W-1:0] rexp [5];
        logic [W-1:0] rb;
        bit rsat;
        int dc, oc0;

        vecs[0] = '{cin: 5'd3, pix: 7'd4, ncin: 3, npix: 4, ben: 1'b1, ren: 1'b0,
                    d: {16'h0100, 16'h0100, 16'h0100}, b: 16'h0080, ex: 16'h0380, sat: 1'b0};
        vecs[1] = '{cin: 5'd2, pix: 7'd1, ncin: 2, npix: 1, ben: 1'b0, ren: 1'b0,
                    d: {16'h0000, 16'h7000, 16'h7000}, b: 16'h0000, ex: 16'h7FFF, sat: 1'b1};
        vecs[2] = '{cin: 5'd1, pix: 7'd1, ncin: 1, npix: 1, ben: 1'b1, ren: 1'b1,
                    d: {16'h0000, 16'h0000, 16'hFF00}, b: 16'h0000, ex: 16'h0000, sat: 1'b0};
        vecs[3] = '{cin: 5'd1, pix: 7'd1, ncin: 1, npix: 1, ben: 1'b1, ren: 1'b0,
                    d: {16'h0000, 16'h0000, 16'hFF00}, b: 16'h0000, ex: 16'hFF00, sat: 1'b0};
        vecs[4] = '{cin: 5'd0, pix: 7'd0, ncin: 1, npix: 1, ben: 1'b1, ren: 1'b0,
                    d: {16'h0000, 16'h0000, 16'h0123}, b: 16'h0010, ex: 16'h0133, sat: 1'b0};
        vecs[5] = '{cin: 5'd2, pix: 7'd2, ncin: 2, npix: 2, ben: 1'b0, ren: 1'b0,
                    d: {16'h0000, 16'h8000, 16'h8000}, b: 16'h0000, ex: 16'h8000, sat: 1'b1};
        vecs[6] = '{cin: 5'd2, pix: 7'd3, ncin: 2, npix: 3, ben: 1'b0, ren: 1'b0,
                    d: {16'h0000, 16'hFF00, 16'h0200}, b: 16'h1234, ex: 16'h0100, sat: 1'b0};
        vecs[7] = '{cin: 5'd20, pix: 7'd1, ncin: 16, npix: 1, ben: 1'b1, ren: 1'b1,
                    d: {16'h0010, 16'h0010, 16'h0010}, b: 16'hFFF0, ex: 16'h00F0, sat: 1'b0};
        vecs[8] = '{cin: 5'd2, pix: 7'd100, ncin: 2, npix: 64, ben: 1'b0, ren: 1'b0,
                    d: {16'h0000, 16'h0002, 16'h0001}, b: 16'h0000, ex: 16'h0003, sat: 1'b0};

        bus.din_valid = 1'b0;
        bus.din = '0;
        bus.dout_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && bus.dout_valid && bus.dout_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dout_unexpected: got %h expected no beat", bus.dout);
                    end else begin
                        check("dout", bus.dout, sb_q.pop_front());
                    end
                    out_cnt++;
                end
                if (rst_n && done) done_cnt++;
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_din_ready", {{(W-1){1'b0}}, bus.din_ready}, 0);
        check("rst_dout_valid", {{(W-1){1'b0}}, bus.dout_valid}, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_busy", {{(W-1){1'b0}}, busy}, 0);
        check("rst_done", {{(W-1){1'b0}}, done}, 0);
        check("rst_sat", {{(W-1){1'b0}}, sat_flag}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

        // Output backpressure on the final pass
        oc0 = out_cnt;
        do_start(5'd1, 7'd3, 1'b0, 1'b0, '0);
        bus.dout_ready = 1'b0;
        send(rep(16'h0011), 1'b1, rep(16'h0011));
        bus.din_valid = 1'b1;
        bus.din = rep(16'h0022);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", k), {{(W-1){1'b0}}, bus.dout_valid}, 1);
            check($sformatf("stall%0d_din_ready", k), {{(W-1){1'b0}}, bus.din_ready}, 0);
            check($sformatf("stall%0d_dout", k), bus.dout, rep(16'h0011));
            @(posedge clk); #1;
        end
        bus.dout_ready = 1'b1;
        send(rep(16'h0022), 1'b1, rep(16'h0022));
        send(rep(16'h0033), 1'b1, rep(16'h0033));
        bus.din_valid = 1'b0;
        wait_done("stall_done");
        check("stall_outs", W'(out_cnt - oc0), 3);

        // Randomised lane-varied job against a reference model
        rsat = 1'b0;
        for (int l = 0; l < PE; l++) begin
            int bv = int'($urandom_range(0, 32'h800)) - 32'h400;
            rb[l*DW +: DW] = bv[DW-1:0];
        end
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 5; p++) begin
                for (int l = 0; l < PE; l++) begin
                    int dv = int'($urandom_range(0, 32'h6000)) - 32'h3000;
                    rd[c][p][l*DW +: DW] = dv[DW-1:0];
                end
            end
        end
        for (int p = 0; p < 5; p++) begin
            for (int l = 0; l < PE; l++) begin
                int s = 0;
                for (int c = 0; c < 3; c++) s += int'($signed(rd[c][p][l*DW +: DW]));
                s += int'($signed(rb[l*DW +: DW]));
                if (s > 32767) begin
                    s = 32767; rsat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768; rsat = 1'b1;
                end
                if (s < 0) s = 0;
                rexp[p][l*DW +: DW] = s[DW-1:0];
            end
        end
        oc0 = out_cnt;
        do_start(5'd3, 7'd5, 1'b1, 1'b1, rb);
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 5; p++) send(rd[c][p], c == 2, rexp[p]);
        end
        bus.din_valid = 1'b0;
        wait_done("model_done");
        check("model_outs", W'(out_cnt - oc0), 5);
        check("model_sat", {{(W-1){1'b0}}, sat_flag}, {{(W-1){1'b0}}, rsat});

        // Reset in the middle of pass 1 aborts the job silently
        do_start(5'd3, 7'd2, 1'b0, 1'b0, '0);
        send(rep(16'h0100), 1'b0, '0);
        send(rep(16'h0100), 1'b0, '0);
        send(rep(16'h0100), 1'b0, '0);
        bus.din_valid = 1'b0;
        dc = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_din_ready", {{(W-1){1'b0}}, bus.din_ready}, 0);
        check("abort_dout_valid", {{(W-1){1'b0}}, bus.dout_valid}, 0);
        check("abort_dout", bus.dout, 0);
        check("abort_busy", {{(W-1){1'b0}}, busy}, 0);
        check("abort_sat", {{(W-1){1'b0}}, sat_flag}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", W'(done_cnt), W'(dc));
        run_vec('{cin: 5'd1, pix: 7'd1, ncin: 1, npix: 1, ben: 1'b1, ren: 1'b0,
                  d: {16'h0000, 16'h0000, 16'h0040}, b: 16'h0008, ex: 16'h0048, sat: 1'b0}, 9);

        check("sb_empty", W'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
